// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve timing, ball kinematics, wall/paddle bounces,
// scoring and match end, all advanced on frame_tick.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for serve_btn, everything at zero
// SERVE     | ball parked at origin, counting frames until release
// PLAY      | ball moving, bounces and edge scoring evaluated per frame
// SCORED    | single-cycle pause to decide match end or next serve
// GAME_OVER | outputs frozen until serve_btn restarts the match
module pong_game_ctrl #(
    parameter int BALL_SPEED  = 2,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_DELAY = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        serve_btn,
    input  logic [3:0]  ball_detect_edge,
    input  logic [7:0]  collision_detect,
    output logic [31:0] ball_off_x,
    output logic [31:0] ball_off_y,
    output logic [31:0] ball_vel_x,
    output logic [31:0] ball_vel_y,
    output logic [3:0]  score_L,
    output logic [3:0]  score_R,
    output logic [2:0]  game_state,
    output logic        game_over
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam int CW = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
    localparam logic [31:0] SPD_P = 32'(BALL_SPEED);
    localparam logic [31:0] SPD_N = 32'(-BALL_SPEED);
    localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dir_right, dir_right_nxt;
    logic [31:0]   off_x, off_y, vel_x, vel_y;
    logic [31:0]   off_x_nxt, off_y_nxt, vel_x_nxt, vel_y_nxt;
    logic [3:0]    sc_l, sc_r, sc_l_nxt, sc_r_nxt;
    logic          vx_pos, vx_neg, vy_pos, vy_neg;
    logic [31:0]   vx_new, vy_new;
    logic          unused_cd;

    assign unused_cd = ^{collision_detect[7:6], collision_detect[4:3]};

    assign vx_pos = !vel_x[31] && (vel_x != 32'd0);
    assign vx_neg = vel_x[31];
    assign vy_pos = !vel_y[31] && (vel_y != 32'd0);
    assign vy_neg = vel_y[31];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dir_right <= 1'b1;
            off_x     <= '0;
            off_y     <= '0;
            vel_x     <= '0;
            vel_y     <= '0;
            sc_l      <= '0;
            sc_r      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dir_right <= dir_right_nxt;
            off_x     <= off_x_nxt;
            off_y     <= off_y_nxt;
            vel_x     <= vel_x_nxt;
            vel_y     <= vel_y_nxt;
            sc_l      <= sc_l_nxt;
            sc_r      <= sc_r_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        dir_right_nxt = dir_right;
        off_x_nxt     = off_x;
        off_y_nxt     = off_y;
        vel_x_nxt     = vel_x;
        vel_y_nxt     = vel_y;
        sc_l_nxt      = sc_l;
        sc_r_nxt      = sc_r;
        vx_new        = vel_x;
        vy_new        = vel_y;

        case (state)
            IDLE, GAME_OVER: begin
                if (serve_btn) begin
                    state_nxt     = SERVE;
                    sc_l_nxt      = '0;
                    sc_r_nxt      = '0;
                    dir_right_nxt = 1'b1;
                    cnt_nxt       = '0;
                    off_x_nxt     = '0;
                    off_y_nxt     = '0;
                    vel_x_nxt     = '0;
                    vel_y_nxt     = '0;
                end
            end
            SERVE: begin
                off_x_nxt = '0;
                off_y_nxt = '0;
                vel_x_nxt = '0;
                vel_y_nxt = '0;
                if (frame_tick) begin
                    if (cnt + CW'(1) == CW'(SERVE_DELAY)) begin
                        state_nxt = PLAY;
                        cnt_nxt   = '0;
                        vel_x_nxt = dir_right ? SPD_P : SPD_N;
                        vel_y_nxt = SPD_P;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    // Vertical walls are independent of the horizontal priority chain
                    if (!ball_detect_edge[2] && vy_neg)
                        vy_new = SPD_P;
                    else if (!ball_detect_edge[0] && vy_pos)
                        vy_new = SPD_N;

                    if (collision_detect[0] && collision_detect[2] && vx_pos) begin
                        vx_new = SPD_N;
                    end else if (collision_detect[1] && collision_detect[5] && vx_neg) begin
                        vx_new = SPD_P;
                    end else if (!ball_detect_edge[1]) begin
                        state_nxt     = SCORED;
                        dir_right_nxt = 1'b0;
                        if (sc_l < WIN) sc_l_nxt = sc_l + 4'd1;
                    end else if (!ball_detect_edge[3]) begin
                        state_nxt     = SCORED;
                        dir_right_nxt = 1'b1;
                        if (sc_r < WIN) sc_r_nxt = sc_r + 4'd1;
                    end

                    // A scoring frame freezes the ball where it left the field
                    if (state_nxt == PLAY) begin
                        vel_x_nxt = vx_new;
                        vel_y_nxt = vy_new;
                        off_x_nxt = off_x + vx_new;
                        off_y_nxt = off_y + vy_new;
                    end
                end
            end
            SCORED: begin
                if (sc_l == WIN || sc_r == WIN) begin
                    state_nxt = GAME_OVER;
                end else begin
                    state_nxt = SERVE;
                    cnt_nxt   = '0;
                    off_x_nxt = '0;
                    off_y_nxt = '0;
                    vel_x_nxt = '0;
                    vel_y_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ball_off_x = off_x;
    assign ball_off_y = off_y;
    assign ball_vel_x = vel_x;
    assign ball_vel_y = vel_y;
    assign score_L    = sc_l;
    assign score_R    = sc_r;
    assign game_state = state;
    assign game_over  = (state == GAME_OVER);

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter BALL_SPEED, default 2: magnitude of ball velocity per frame on each axis.
REQ-002 Parameter WIN_SCORE, default 9: score at which a match ends.
REQ-003 Parameter SERVE_DELAY, default 60: frame ticks between serve start and ball release.
REQ-004 Port clk, input, 1: single clock; all state SHALL be registered on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port frame_tick, input, 1: one-cycle pulse, once per video frame.
REQ-007 Port serve_btn, input, 1: level; start or restart request.
REQ-008 Port ball_detect_edge, input, 4: active-low screen-edge flags; bit0 = bottom, bit1 = right, bit2 = top, bit3 = left.
REQ-009 Port collision_detect, input, 8: active-high flags; bit0 = right-paddle x overlap, bit1 = left-paddle x overlap, bit2 = right-paddle y overlap, bit5 = left-paddle y overlap; other bits unused.
REQ-010 Port ball_off_x, ball_off_y, output, 32 each: two's-complement ball offset from its initial position.
REQ-011 Port ball_vel_x, ball_vel_y, output, 32 each: two's-complement current velocity.
REQ-012 Port score_L, score_R, output, 4 each: player scores.
REQ-013 Port game_state, output, 3: encoding IDLE=0, SERVE=1, PLAY=2, SCORED=3, GAME_OVER=4.
REQ-014 Port game_over, output, 1: high while in GAME_OVER.

Function
REQ-015 The FSM SHALL have the states IDLE, SERVE, PLAY, SCORED and GAME_OVER.
REQ-016 IDLE -> SERVE on the first clk with serve_btn=1; on entry, scores SHALL be cleared to 0 and serve_dir set to right.
REQ-017 SERVE behaviour:
- Offsets SHALL be held at 0 and velocities at 0.
- A frame counter SHALL increment on each frame_tick.
- On the frame_tick that makes the count equal SERVE_DELAY: next cycle state = PLAY, counter cleared, ball_vel_x = +BALL_SPEED if serve_dir = right else -BALL_SPEED, ball_vel_y = +BALL_SPEED.
REQ-018 PLAY: updates SHALL occur only on cycles with frame_tick=1; all other cycles hold every register.
REQ-019 PLAY tick evaluation, using inputs sampled that cycle, in this priority:
- (a) Right paddle hit (collision_detect[0] & [2] & vel_x>0): vel_x = -BALL_SPEED.
- (b) Else left paddle hit (collision_detect[1] & [5] & vel_x<0): vel_x = +BALL_SPEED.
- (c) Else right edge (ball_detect_edge[1]=0): score_L increments, serve_dir = left, next state SCORED.
- (d) Else left edge (ball_detect_edge[3]=0): score_R increments, serve_dir = right, next state SCORED.
REQ-020 Independently on the same tick:
- ball_detect_edge[2]=0 & vel_y<0 -> vel_y = +BALL_SPEED.
- ball_detect_edge[0]=0 & vel_y>0 -> vel_y = -BALL_SPEED.
- A wall flag with velocity already pointing away SHALL be ignored (no double bounce).
REQ-021 In PLAY, when no score occurs, offsets SHALL update on the same tick using the new velocity (off += new vel); outputs are visible one clk after frame_tick.
REQ-022 On a scoring tick, offsets and velocities SHALL NOT change.
REQ-023 SCORED SHALL last exactly one clk:
- -> GAME_OVER if either score equals WIN_SCORE.
- Else -> SERVE, with offsets, velocities and the counter cleared.
REQ-024 Scores SHALL NOT exceed WIN_SCORE; no wrap-around.
REQ-025 GAME_OVER SHALL hold all outputs until serve_btn=1, then -> IDLE-equivalent restart: scores cleared, serve_dir = right, state SERVE.
REQ-026 serve_btn SHALL be ignored in SERVE, PLAY and SCORED.
REQ-027 Offset arithmetic SHALL be 32-bit two's complement, wrapping without saturation.
REQ-028 The frame_tick-to-output update latency SHALL be exactly 1 clk in all states.

Reset
REQ-029 While reset=1 (asynchronously), the block SHALL hold:
- game_state = IDLE, game_over = 0.
- All offsets, velocities and scores = 0.
- Frame counter = 0, serve_dir = right.
REQ-030 Reset asserted mid-PLAY or mid-SERVE SHALL abort immediately; after release the block SHALL remain in IDLE until serve_btn.

Verification
REQ-031 Serve: reset, serve_btn pulse, 60 frame_ticks -> PLAY with vel = (+2, +2); after 3 more ticks, off = (6, 6).
REQ-032 Right paddle bounce: PLAY, vel_x = +2, collision_detect = 0x05 on a tick -> vel_x = -2 and off_x decreases by 2 that tick; repeat flag next tick -> no change in sign.
REQ-033 Top-wall bounce: ball_detect_edge = 4'b1011 with vel_y = -2 -> vel_y = +2; same with vel_y = +2 -> unchanged.
REQ-034 Score: ball_detect_edge = 4'b1101, no paddle collision -> score_L = 1, SCORED for 1 clk, then SERVE with offsets 0; released vel_x = -2.
REQ-035 Match end: score_R = 8, left edge tick -> score_R = 9, GAME_OVER, game_over = 1; serve_btn -> scores 0, SERVE.
REQ-036 Priority and reset: paddle hit plus right edge on the same tick -> bounce, no score; reset asserted mid-PLAY without a clock edge -> outputs 0 and IDLE immediately.
